// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Imported by the clear sequencer and the top level.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Self-clearing sequencer: walks every register address after reset
// or on request, then reports the file as usable.
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req_i,
  output logic          ready_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = (cnt_q == AW'(NREGS - 1));

  // Next state: count through the array, stop on the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_CLEAR: begin
        if (last) begin
          state_d = RF_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      RF_READY: begin
        if (clear_req_i) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers; reset always restarts a full clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o    = (state_q == RF_READY);
  assign clr_we_o   = (state_q == RF_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised decode-stage register file with optional x0 hardwiring,
// write-to-read bypass and a sequenced clear in place of array reset.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int AW       = rf_aw(NREGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_req,
  output logic            ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            reg_write,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            wr_en;
  logic            z1, z2;

  rf_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_req_i (clear_req),
    .ready_o     (ready),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  // A write is real only when the file is usable and not aimed at x0.
  assign wr_en = reg_write && ready &&
                 !((ZERO_REG != 0) && (rd == '0));

  assign z1 = (ZERO_REG != 0) && (rs1 == '0);
  assign z2 = (ZERO_REG != 0) && (rs2 == '0);

  // Storage: sequencer zeroes an entry while clearing, else normal write.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs_q[clr_addr] <= '0;
    end else if (wr_en) begin
      regs_q[rd] <= write_data;
    end
  end

  // Port 1 read: forced zero when not ready or x0, else bypass or array.
  always_comb begin
    read_data1 = '0;
    if (ready && !z1) begin
      if ((BYPASS != 0) && wr_en && (rd == rs1)) begin
        read_data1 = write_data;
      end else begin
        read_data1 = regs_q[rs1];
      end
    end
  end

  // Port 2 read: same rules as port 1, fully independent.
  always_comb begin
    read_data2 = '0;
    if (ready && !z2) begin
      if ((BYPASS != 0) && wr_en && (rd == rs2)) begin
        read_data2 = write_data;
      end else begin
        read_data2 = regs_q[rs2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: default, no-bypass/plain-x0,
// and 16x64 configurations driven side by side.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req, reg_write;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] wd;
  logic        rdy_a, rdy_b;
  logic [31:0] a1, a2, b1, b2;

  logic        clear_req_w, reg_write_w;
  logic [3:0]  rs1_w, rs2_w, rd_w;
  logic [63:0] wd_w, w1, w2;
  logic        rdy_w;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       tag;
    int          src;
    logic [63:0] exp;
  } sb_t;

  sb_t sb_q[$];

  always #5 clk = ~clk;

  regfile_param dut_a (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(rdy_a),
    .rs1(rs1), .rs2(rs2), .rd(rd), .write_data(wd),
    .reg_write(reg_write), .read_data1(a1), .read_data2(a2)
  );

  regfile_param #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(rdy_b),
    .rs1(rs1), .rs2(rs2), .rd(rd), .write_data(wd),
    .reg_write(reg_write), .read_data1(b1), .read_data2(b2)
  );

  regfile_param #(.XLEN(64), .NREGS(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req_w), .ready(rdy_w),
    .rs1(rs1_w), .rs2(rs2_w), .rd(rd_w), .write_data(wd_w),
    .reg_write(reg_write_w), .read_data1(w1), .read_data2(w2)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int src);
    case (src)
      0: return {32'h0, a1};
      1: return {32'h0, a2};
      2: return {32'h0, b1};
      3: return {32'h0, b2};
      4: return w1;
      5: return w2;
      6: return {63'h0, rdy_a};
      7: return {63'h0, rdy_b};
      default: return {63'h0, rdy_w};
    endcase
  endfunction

  task automatic push(input string tag, input int src,
                      input logic [63:0] exp);
    sb_t e;
    e.tag = tag;
    e.src = src;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.src), e.exp);
    end
  endtask

  // Count rising edges until ready rises on dut_a (and dut_w if asked).
  task automatic count_ready(input string tag, input int exp_a,
                             input bit use_w, input int exp_w);
    int na = 0;
    int nw = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (rdy_a && na == 0) na = k;
      if (rdy_w && nw == 0) nw = k;
      if (na != 0 && (!use_w || nw != 0)) break;
    end
    chk({tag, "_edges"}, 64'(na), 64'(exp_a));
    if (use_w) chk({tag, "_edges_w"}, 64'(nw), 64'(exp_w));
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; reg_write = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; wd = '0;
    clear_req_w = 1'b0; reg_write_w = 1'b0;
    rs1_w = '0; rs2_w = '0; rd_w = '0; wd_w = '0;

    #2;
    rs1 = 5'd3; rs2 = 5'd4;
    push("rst_ready_a", 6, 0);
    push("rst_ready_w", 8, 0);
    push("rst_rd1_a", 0, 0);
    push("rst_rd1_b", 2, 0);
    drain();

    @(negedge clk);
    rst_n = 1'b1;
    count_ready("init", 32, 1'b1, 16);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      push("init_zero_rd1", 0, 0);
      push("init_zero_rd2", 1, 0);
      push("init_zero_b", 2, 0);
      #1;
      drain();
    end

    @(negedge clk);
    rd = 5'd5; wd = 32'hDEADBEEF; reg_write = 1'b1; rs2 = 5'd5;
    push("byp_same_cycle", 1, 64'hDEADBEEF);
    push("nobyp_same_cycle", 3, 0);
    #1;
    drain();
    @(negedge clk);
    reg_write = 1'b0; rs1 = 5'd5;
    push("byp_next_a", 0, 64'hDEADBEEF);
    push("byp_next_b", 2, 64'hDEADBEEF);
    #1;
    drain();

    @(negedge clk);
    rd = 5'd0; wd = 32'h00001234; reg_write = 1'b1; rs2 = 5'd0;
    push("x0_byp_a", 1, 0);
    #1;
    drain();
    @(negedge clk);
    reg_write = 1'b0; rs1 = 5'd0;
    push("x0_zero_a", 0, 0);
    push("x0_plain_b", 2, 64'h00001234);
    #1;
    drain();

    @(negedge clk);
    rd = 5'd7; wd = 32'hA5A5A5A5; reg_write = 1'b1;
    @(negedge clk);
    rd = 5'd9; wd = 32'h11111111; clear_req = 1'b1; rs1 = 5'd9;
    push("clr_req_byp", 0, 64'h11111111);
    #1;
    drain();
    @(posedge clk);
    #1;
    push("clr_ready_low", 6, 0);
    drain();
    clear_req = 1'b0; rd = 5'd3; wd = 32'h0000FFFF; rs1 = 5'd7;
    push("clr_read_zero", 0, 0);
    #1;
    drain();
    count_ready("clear", 32, 1'b0, 0);
    @(negedge clk);
    reg_write = 1'b0;
    rs1 = 5'd7; rs2 = 5'd9;
    push("clr_x7", 0, 0);
    push("clr_x9", 1, 0);
    push("clr_x7_b", 2, 0);
    #1;
    drain();
    @(negedge clk);
    rs1 = 5'd3;
    push("clr_drop_x3", 0, 0);
    #1;
    drain();

    @(negedge clk);
    rd = 5'd4; wd = 32'hCAFEF00D; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0; clear_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    repeat (9) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rs1 = 5'd4;
    #1;
    push("mid_rst_ready", 6, 0);
    push("mid_rst_rd", 0, 0);
    push("mid_rst_ready_w", 8, 0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    count_ready("mid_rst", 32, 1'b1, 16);
    @(negedge clk);
    push("mid_rst_x4", 0, 0);
    #1;
    drain();

    @(negedge clk);
    rd_w = 4'd15; wd_w = 64'h0123456789ABCDEF; reg_write_w = 1'b1;
    rs2_w = 4'd15;
    push("w_byp", 5, 64'h0123456789ABCDEF);
    #1;
    drain();
    @(negedge clk);
    reg_write_w = 1'b0; rs1_w = 4'd15; rs2_w = 4'd14;
    push("w_x15", 4, 64'h0123456789ABCDEF);
    push("w_x14", 5, 0);
    #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
